// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI arbiter.
package spi_arb_pkg;

  localparam int SPI_CMD_W  = 16;
  localparam int SPI_RESP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_GAP
  } arb_state_t;

endpackage

// File: rtl/spi_arb_pick.sv
// Combinational winner selection for spi_arbiter.
// SPI_ARB_RR_EN defined: round-robin from ptr; undefined: fixed priority, lowest index wins.
module spi_arb_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any
);

`ifdef SPI_ARB_RR_EN
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = IDX_W'(i);
        any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_arbiter.sv
// Shares one 16-bit SPI monarch between NUM_REQ requesters, with GAP_CYC idle clocks after each transfer.
// Arbitration policy is chosen in spi_arb_pick by SPI_ARB_RR_EN (round-robin) or its absence (fixed).
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [SPI_CMD_W*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic [SPI_RESP_W-1:0]        resp,
  output logic                         busy,
  output logic                         spi_snd,
  output logic [SPI_CMD_W-1:0]         spi_cmd,
  input  logic                         spi_done,
  input  logic [SPI_RESP_W-1:0]        spi_resp
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t           state_reg;
  logic [IDX_W-1:0]     owner_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [7:0]           gap_cnt_reg;
  logic [IDX_W-1:0]     win;
  logic                 any;
  logic [SPI_CMD_W-1:0] cmd_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
    assign cmd_arr[gi] = req_cmd[gi*SPI_CMD_W +: SPI_CMD_W];
  end

  spi_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .win (win),
    .any (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= '0;
      ptr_reg     <= '0;
      gap_cnt_reg <= '0;
      grant       <= '0;
      ack         <= '0;
      resp        <= '0;
      busy        <= 1'b0;
      spi_snd     <= 1'b0;
      spi_cmd     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any) begin
            owner_reg <= win;
            spi_cmd   <= cmd_arr[win];
            grant     <= ONE_HOT0 << win;
            busy      <= 1'b1;
            spi_snd   <= 1'b1;
            state_reg <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          spi_snd   <= 1'b0;
          state_reg <= ST_WAIT;
        end
        // The monarch clears done on the LAUNCH->WAIT edge, so any done seen here is fresh.
        ST_WAIT: begin
          if (spi_done) begin
            resp      <= spi_resp;
            ack       <= ONE_HOT0 << owner_reg;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack         <= '0;
          grant       <= '0;
          ptr_reg     <= (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
          gap_cnt_reg <= 8'(GAP_CYC);
          if (GAP_CYC == 0) begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg <= 8'd1) begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
